dmux1t8_32_buf: RTL and testbench

- 1-to-8 write distributor for 32-bit data; it performs the reverse operation of the 8:1 source select.
- Accepts a word plus a 3-bit channel select through a valid/ready handshake and steers it into one of eight one-entry output buffers.
- Each output buffer has its own valid/ready handshake.
- Sits between the CPU-side write path and per-channel consumers (display, peripheral, interrupt-vector registers).

---
 rtl/dmux1t8_32_buf_pkg.sv | 30 +++
 rtl/dmux1t8_32_buf_chan_buf.sv | 41 ++++
 rtl/dmux1t8_32_buf.sv | 78 +++++++
 tb/tb_dmux1t8_32_buf.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmux1t8_32_buf_pkg.sv
// Shared definitions for the dmux1t8_32_buf write distributor:
// channel count, select width, select decode and channel slice offsets.
package dmux1t8_32_buf_pkg;

    localparam int DMUX_NCH   = 8;
    localparam int DMUX_SEL_W = 3;

    // One-hot decode of a channel select.
    function automatic logic [DMUX_NCH-1:0] sel_onehot(input logic [DMUX_SEL_W-1:0] sel);
        logic [DMUX_NCH-1:0] oh;
        case (sel)
            3'd0:    oh = 8'b0000_0001;
            3'd1:    oh = 8'b0000_0010;
            3'd2:    oh = 8'b0000_0100;
            3'd3:    oh = 8'b0000_1000;
            3'd4:    oh = 8'b0001_0000;
            3'd5:    oh = 8'b0010_0000;
            3'd6:    oh = 8'b0100_0000;
            3'd7:    oh = 8'b1000_0000;
            default: oh = 8'b0000_0000;
        endcase
        return oh;
    endfunction

    // Bit offset of channel k inside the flattened output bus.
    function automatic int chan_slice(input int k, input int dw);
        return k * dw;
    endfunction

endpackage

// File: rtl/dmux1t8_32_buf_chan_buf.sv
// Single-entry output buffer for one channel of dmux1t8_32_buf.
// A load always wins over a drain, so a full buffer can be refilled
// in the same cycle it is emptied. The data register keeps its last
// value after a drain and is cleared only by reset.
module dmux_chan_buf #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] d,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] q
);

    // Valid flag: set on load, cleared on handshake, otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end else begin
            valid <= valid;
        end
    end

    // Data register: captures d on load, holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= {DW{1'b0}};
        end else if (load) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/dmux1t8_32_buf.sv
// dmux1t8_32_buf: 1-to-8 write distributor with one-entry buffer per channel.
// A word accepted on the input handshake lands in channel s one cycle later.
// Optional feature macro: DMUX_STALL_CNT_EN adds a saturating stall counter
// (stall_cnt, CNT_W bits) counting cycles with in_valid=1 and in_ready=0.
module dmux1t8_32_buf
    import dmux1t8_32_buf_pkg::*;
#(
    parameter int DW = 32
`ifdef DMUX_STALL_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DMUX_SEL_W-1:0]   s,
    input  logic [DW-1:0]           d,
    output logic [DMUX_NCH-1:0]     out_valid,
    input  logic [DMUX_NCH-1:0]     out_ready,
    output logic [DMUX_NCH*DW-1:0]  o
`ifdef DMUX_STALL_CNT_EN
    , output logic [CNT_W-1:0]      stall_cnt
`endif
);

    logic                accept;
    logic [DMUX_NCH-1:0] load;

    // Input readiness: target channel is empty or being drained this cycle.
    always_comb begin
        in_ready = !out_valid[s] | out_ready[s];
        accept   = in_valid & in_ready;
    end

    // Select decode, gated so an unknown s with in_valid low loads nothing.
    always_comb begin
        if (accept) begin
            load = sel_onehot(s);
        end else begin
            load = {DMUX_NCH{1'b0}};
        end
    end

    genvar k;
    generate
        for (k = 0; k < DMUX_NCH; k++) begin : g_chan
            dmux_chan_buf #(
                .DW(DW)
            ) u_buf (
                .clk   (clk),
                .rst   (rst),
                .load  (load[k]),
                .d     (d),
                .ready (out_ready[k]),
                .valid (out_valid[k]),
                .q     (o[chan_slice(k, DW) +: DW])
            );
        end
    endgenerate

`ifdef DMUX_STALL_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stall counter: count refused input cycles, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= {CNT_W{1'b0}};
        end else if (in_valid && !in_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end else begin
            stall_cnt <= stall_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_dmux1t8_32_buf.sv
// Self-checking bench for dmux1t8_32_buf: directed scenarios plus a random
// phase, checked against a per-channel full/data model of the buffers.
// With DMUX_STALL_CNT_EN defined the DUT is built with CNT_W=4.
module tb_dmux1t8_32_buf;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   s;
    logic [31:0]  d;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic [255:0] o;
`ifdef DMUX_STALL_CNT_EN
    logic [3:0]   stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // reference model: one full flag and one data word per channel
    bit          m_full [8];
    logic [31:0] m_data [8];
    int          m_stall;
    localparam int CNT_MAX = 15;

    bit          pend;
    logic [2:0]  ps;
    logic [31:0] pd;
    logic [31:0] got_q [$];

`ifdef DMUX_STALL_CNT_EN
    dmux1t8_32_buf #(.DW(32), .CNT_W(4)) dut (
`else
    dmux1t8_32_buf #(.DW(32)) dut (
`endif
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o)
`ifdef DMUX_STALL_CNT_EN
        , .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 8; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = 32'h0;
        end
        m_stall = 0;
        pend    = 1'b0;
    endtask

    task automatic check_all(input string tag, input bit rdy);
        logic [7:0]   ev;
        logic [255:0] eo;
        for (int k = 0; k < 8; k++) begin
            ev[k]           = m_full[k];
            eo[k*32 +: 32]  = m_data[k];
        end
        chk({tag, "_rdy"}, in_ready, rdy);
        chk({tag, "_ov"}, out_valid, ev);
        chk({tag, "_o"}, o, eo);
`ifdef DMUX_STALL_CNT_EN
        chk({tag, "_stall"}, stall_cnt, m_stall);
`endif
    endtask

    // one clock: check current state, advance model across the edge
    task automatic cycle(input string tag);
        bit rdy;
        bit acc;
        #1;
        rdy = !m_full[s] || out_ready[s];
        check_all(tag, rdy);
        if (pend && in_valid) begin
            assert (s === ps && d === pd) else begin
                errors++;
                $error("FAIL upstream_rule observed=%0d/%h expected=%0d/%h", s, d, ps, pd);
            end
        end
        if (out_valid[0] && out_ready[0]) got_q.push_back(o[31:0]);
        acc  = in_valid && rdy;
        pend = in_valid && !acc;
        ps   = s;
        pd   = d;
        if (in_valid && !rdy && m_stall < CNT_MAX) m_stall++;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            if (m_full[k] && out_ready[k]) m_full[k] = 1'b0;
        end
        if (acc) begin
            m_full[s] = 1'b1;
            m_data[s] = d;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; s = 3'd0; d = 32'h0; out_ready = 8'h00;
        model_clear();
        repeat (2) @(negedge clk);
        chk("reset_ov", out_valid, 8'h00);
        chk("reset_o", o, 256'h0);
`ifdef DMUX_STALL_CNT_EN
        chk("reset_stall", stall_cnt, 4'h0);
`endif
        rst = 1'b0;
        cycle("idle");

        // single write to channel 5, then hold for 10 cycles
        s = 3'd5; d = 32'hDEADBEEF; in_valid = 1'b1;
        cycle("wr5");
        in_valid = 1'b0; s = 3'd0; d = 32'h0;
        #1;
        chk("wr5_ov", out_valid, 8'h20);
        chk("wr5_data", o[191:160], 32'hDEADBEEF);
        repeat (10) cycle("hold5");

        // back-pressure on channel 5
        s = 3'd5; d = 32'h1; in_valid = 1'b1;
        #1;
        chk("bp_rdy0", in_ready, 1'b0);
        repeat (3) cycle("bp");
`ifdef DMUX_STALL_CNT_EN
        #1;
        chk("bp_stall3", stall_cnt, 4'd3);
`endif
        out_ready = 8'h20;
        #1;
        chk("bp_rdy1", in_ready, 1'b1);
        cycle("bp_rel");
        in_valid = 1'b0; out_ready = 8'h00;
        #1;
        chk("bp_data", o[191:160], 32'h1);
        chk("bp_ov5", out_valid[5], 1'b1);
        out_ready = 8'h20;
        cycle("drain5");
        out_ready = 8'h00;

        // streaming 0..15 through channel 0
        got_q.delete();
        out_ready = 8'h01; s = 3'd0;
        for (int i = 0; i < 16; i++) begin
            d = i; in_valid = 1'b1;
            #1;
            chk("stream_rdy", in_ready, 1'b1);
            cycle("stream");
        end
        in_valid = 1'b0;
        cycle("stream_tail");
        out_ready = 8'h00;
        chk("stream_cnt", got_q.size(), 16);
        for (int i = 0; i < 16 && i < got_q.size(); i++) chk("stream_word", got_q[i], i);

        // cross-channel fill and simultaneous drain
        for (int k = 0; k < 8; k++) begin
            s = k; d = 32'h10 + k; in_valid = 1'b1;
            cycle("fill");
        end
        in_valid = 1'b0; s = 3'd0;
        out_ready = 8'hFF;
        #1;
        chk("xc_ov_full", out_valid, 8'hFF);
        for (int k = 0; k < 8; k++) chk("xc_deliver", o[k*32 +: 32], 32'h10 + k);
        cycle("xc_drain");
        out_ready = 8'h00;
        #1;
        chk("xc_ov_empty", out_valid, 8'h00);
        for (int k = 0; k < 8; k++) chk("xc_retain", o[k*32 +: 32], 32'h10 + k);

        // random traffic obeying the upstream stability rule
        for (int i = 0; i < 300; i++) begin
            if (!pend) begin
                s = $urandom_range(0, 7);
                d = $urandom;
                in_valid = $urandom_range(0, 1);
            end else begin
                in_valid = 1'b1;
            end
            out_ready = $urandom;
            cycle("rand");
        end
        in_valid = 1'b0; out_ready = 8'hFF;
        cycle("flush");
        out_ready = 8'h00;

`ifdef DMUX_STALL_CNT_EN
        // saturation: long stall on a full channel
        s = 3'd3; d = 32'h33; in_valid = 1'b1;
        cycle("sat_fill");
        d = 32'h34;
        repeat (20) cycle("sat");
        #1;
        chk("sat_stall", stall_cnt, 4'hF);
        in_valid = 1'b0; out_ready = 8'hFF;
        cycle("sat_drain");
        out_ready = 8'h00;
`endif

        // asynchronous reset mid-stream with channels 2 and 5 full
        s = 3'd2; d = 32'hAAAA0002; in_valid = 1'b1;
        cycle("pre_rst2");
        s = 3'd5; d = 32'hAAAA0005;
        cycle("pre_rst5");
        in_valid = 1'b0; s = 3'd0;
        #1;
        chk("pre_rst_ov", out_valid, 8'h24);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_ov", out_valid, 8'h00);
        chk("arst_o", o, 256'h0);
`ifdef DMUX_STALL_CNT_EN
        chk("arst_stall", stall_cnt, 4'h0);
`endif
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        cycle("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
